// File: rtl/tt3_sequencer.sv
// tt3_sequencer: sweeps all 8 input vectors of a 3-input cell and checks ZN against a truth table
// Ports: CK clock, RST async active-high reset, START sweep pulse, ZN cell output under test;
//        A1..A3 applied vector (A1 = MSB), BUSY sweep running, DONE sweep complete (held),
//        PASS done with no mismatches, ERR_CNT mismatch count (saturates at 8),
//        FAIL_VEC per-vector mismatch flags.
// Params: SETTLE hold cycles per vector before sampling (1..15), EXP_TT expected truth table.
// Macro TT3_SEQ_LOG_EN: prints each sample and the final error count; no effect on outputs.
module tt3_sequencer #(
  parameter int          SETTLE = 2,
  parameter logic [7:0]  EXP_TT = 8'h01
) (
  input  logic       CK,
  input  logic       RST,
  input  logic       START,
  input  logic       ZN,
  output logic       A1,
  output logic       A2,
  output logic       A3,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] ERR_CNT,
  output logic [7:0] FAIL_VEC
);
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;
  state_t     state_q, state_d;
  logic [2:0] vec_q, vec_d, a_q, a_d;
  logic [3:0] cnt_q, cnt_d, err_q, err_d;
  logic [7:0] fail_q, fail_d;
  logic       busy_q, busy_d, done_q, done_d, pass_q, pass_d, arm_q, mis;
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fail_d  = fail_q;
    // case inequality so an X/Z on ZN is scored as a mismatch
    mis     = ZN !== EXP_TT[vec_q];
    case (state_q)
      S_IDLE, S_DONE:
        // arm_q blocks a START that lands on the reset release edge
        if (START && arm_q) begin
          state_d = S_SETTLE;
          vec_d   = 3'd0;
          cnt_d   = 4'd0;
          err_d   = 4'd0;
          fail_d  = 8'd0;
        end
      S_SETTLE:
        if (cnt_q == 4'(SETTLE - 1)) begin
          state_d = S_SAMPLE;
          cnt_d   = 4'd0;
        end else cnt_d = cnt_q + 4'd1;
      S_SAMPLE: begin
        if (mis) begin
          fail_d[vec_q] = 1'b1;
          err_d         = (err_q == 4'd8) ? 4'd8 : err_q + 4'd1;
        end
        state_d = (vec_q == 3'd7) ? S_DONE : S_SETTLE;
        vec_d   = (vec_q == 3'd7) ? vec_q : vec_q + 3'd1;
      end
      default: state_d = S_IDLE;
    endcase
    // outputs are registered from next-state values so they line up with the state
    busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    done_d = state_d == S_DONE;
    pass_d = done_d && (err_d == 4'd0);
    a_d    = busy_d ? vec_d : 3'd0;
  end
  always_ff @(posedge CK or posedge RST)
    if (RST) begin
      state_q <= S_IDLE;
      vec_q   <= 3'd0;
      cnt_q   <= 4'd0;
      err_q   <= 4'd0;
      fail_q  <= 8'd0;
      a_q     <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fail_q  <= fail_d;
      a_q     <= a_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      arm_q   <= 1'b1;
    end
`ifdef TT3_SEQ_LOG_EN
  always @(posedge CK)
    if (!RST && state_q == S_SAMPLE) begin
      $display("%b: %b", vec_q, ZN);
      if (state_d == S_DONE) $display("errors: %0d", err_d);
    end
`endif
  assign {A1, A2, A3} = a_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign ERR_CNT  = err_q;
  assign FAIL_VEC = fail_q;
endmodule
